// File: rtl/mcu0_param_core_if.sv
// Memory bus between the mcu0_param_core (master) and a shared instruction/data memory (slave).
// The bus uses a req/ack handshake, so the memory may insert wait states.
interface mcu0_param_core_if #(
   parameter int DW = 16,
   parameter int AW = 12
) ();
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mcu0_param_core.sv
// Multi-cycle accumulator MCU: FETCH/DECODE/MEM/HALT state machine on one shared req/ack memory.
// Optional feature: define MCU0_CALL_EN to add a one-level link register with CALL (B) and RET (C).
module mcu0_param_core #(
   parameter int DW = 16,
   parameter int AW = 12
) (
   input  logic              clock,
   input  logic              reset_n,
   mcu0_param_core_if.master bus,
   output logic [AW-1:0]     pc,
   output logic [DW-1:0]     acc,
   output logic [DW-1:0]     sw,
   output logic              halted
);
   localparam logic [3:0] OP_LD   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_JMP  = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_CMP  = 4'h4;
   localparam logic [3:0] OP_JEQ  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_JLT  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_LDI  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;
`ifdef MCU0_CALL_EN
   localparam logic [3:0] OP_CALL = 4'hB;
   localparam logic [3:0] OP_RET  = 4'hC;
`endif
   localparam logic [AW-1:0] PC_STEP = AW'(DW / 8);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_MEM    = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] acc_q, acc_d;
   // Only the opcode and C field of IR are ever used, so only those are kept.
   logic [3:0]    op_q, op_d;
   logic [AW-1:0] c_q, c_d;
   logic          n_q, n_d;
   logic          z_q, z_d;
`ifdef MCU0_CALL_EN
   logic [AW-1:0] lr_q, lr_d;
`endif

   logic          req_c;
   logic          we_c;
   logic [AW-1:0] addr_c;
   logic [DW-1:0] alu_r;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         acc_q   <= '0;
         op_q    <= '0;
         c_q     <= '0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
`ifdef MCU0_CALL_EN
         lr_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         c_q     <= c_d;
         n_q     <= n_d;
         z_q     <= z_d;
`ifdef MCU0_CALL_EN
         lr_q    <= lr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      acc_d   = acc_q;
      op_d    = op_q;
      c_d     = c_q;
      n_d     = n_q;
      z_d     = z_q;
`ifdef MCU0_CALL_EN
      lr_d    = lr_q;
`endif
      req_c   = 1'b0;
      we_c    = 1'b0;
      addr_c  = pc_q;

      case (op_q)
         OP_ADD:  alu_r = acc_q + bus.mem_rdata;
         OP_SUB:  alu_r = acc_q - bus.mem_rdata;
         OP_AND:  alu_r = acc_q & bus.mem_rdata;
         OP_OR:   alu_r = acc_q | bus.mem_rdata;
         default: alu_r = acc_q;
      endcase

      case (state_q)
         S_FETCH: begin
            req_c = 1'b1;
            if (bus.mem_ack) begin
               op_d    = bus.mem_rdata[DW-1:DW-4];
               c_d     = bus.mem_rdata[AW-1:0];
               pc_d    = pc_q + PC_STEP;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_FETCH;
            case (op_q)
               OP_LD, OP_ADD, OP_CMP, OP_SUB, OP_AND, OP_OR, OP_ST: state_d = S_MEM;
               OP_JMP:  pc_d = c_q;
               OP_JEQ:  if (z_q) pc_d = c_q;
               OP_JLT:  if (n_q) pc_d = c_q;
               OP_LDI:  acc_d = DW'(c_q);
               OP_HALT: state_d = S_HALT;
`ifdef MCU0_CALL_EN
               OP_CALL: begin
                  lr_d = pc_q;
                  pc_d = c_q;
               end
               OP_RET:  pc_d = lr_q;
`endif
               default: ;
            endcase
         end
         S_MEM: begin
            req_c  = 1'b1;
            addr_c = c_q;
            we_c   = (op_q == OP_ST);
            if (bus.mem_ack) begin
               state_d = S_FETCH;
               case (op_q)
                  OP_LD: acc_d = bus.mem_rdata;
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     acc_d = alu_r;
                     z_d   = (alu_r == '0);
                     n_d   = alu_r[DW-1];
                  end
                  OP_CMP: begin
                     n_d = (acc_q < bus.mem_rdata);
                     z_d = (acc_q == bus.mem_rdata);
                  end
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   // The reset state is FETCH, so the request is gated by reset_n to drop it immediately.
   assign bus.mem_req   = req_c & reset_n;
   assign bus.mem_we    = we_c & reset_n;
   assign bus.mem_addr  = addr_c;
   assign bus.mem_wdata = acc_q;

   assign pc     = pc_q;
   assign acc    = acc_q;
   assign sw     = {n_q, z_q, {(DW-2){1'b0}}};
   assign halted = (state_q == S_HALT);
endmodule

// File: tb/tb_mcu0_param_core.sv
// Bench for mcu0_param_core: directed program table, reset/wait-state sequences,
// and random programs checked step by step against an instruction-level model.
module tb_mcu0_param_core;
   localparam int DW = 16;
   localparam int AW = 12;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic [AW-1:0] pc;
   logic [DW-1:0] acc;
   logic [DW-1:0] sw;
   logic          halted;

   mcu0_param_core_if #(.DW(DW), .AW(AW)) bus ();

   mcu0_param_core #(.DW(DW), .AW(AW)) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus),
      .pc     (pc),
      .acc    (acc),
      .sw     (sw),
      .halted (halted)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] tmem [0:2047];
   logic [15:0] mm   [0:2047];
   int          delay = 0;
   bit          noise = 1'b0;

   logic [11:0] m_pc, m_lr;
   logic [15:0] m_a;
   bit          m_n, m_z, m_halt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory responder with programmable wait states and optional stray acks while idle.
   bit          busy = 1'b0;
   int          wcnt = 0;
   logic [11:0] la;
   logic        lw;
   logic [15:0] ld;
   initial begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
   end
   always @(negedge clock) begin
      if (!reset_n) begin
         bus.mem_ack = 1'b0;
         busy = 1'b0;
      end else if (bus.mem_req) begin
         if (!busy) begin
            busy = 1'b1;
            wcnt = 0;
            la = bus.mem_addr;
            lw = bus.mem_we;
            ld = bus.mem_wdata;
         end else begin
            vectors++;
            if (bus.mem_addr !== la || bus.mem_we !== lw || (lw && bus.mem_wdata !== ld)) begin
               miscompares++;
               $display("FAIL hold: addr/we/wdata %h/%b/%h, expected %h/%b/%h",
                        bus.mem_addr, bus.mem_we, bus.mem_wdata, la, lw, ld);
            end
         end
         if (wcnt >= delay) begin
            bus.mem_ack = 1'b1;
            busy = 1'b0;
            if (bus.mem_we) tmem[bus.mem_addr[11:1]] = bus.mem_wdata;
            else bus.mem_rdata = tmem[bus.mem_addr[11:1]];
         end else begin
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 16'($urandom);
            wcnt++;
         end
      end else begin
         if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL req_drop: req 0 before ack, expected 1");
            busy = 1'b0;
         end
         bus.mem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.mem_rdata = 16'($urandom);
      end
   end

   // Instruction-level reference: one call executes one instruction and returns its cycle cost.
   task automatic model_step(output int cost);
      logic [15:0] w, m, r;
      logic [3:0]  op;
      logic [11:0] c;
      cost = 0;
      if (m_halt) return;
      w  = mm[m_pc[11:1]];
      m_pc = m_pc + 12'd2;
      op = w[15:12];
      c  = w[11:0];
      m  = mm[c[11:1]];
      cost = 2 + delay;
      if (op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h6, 4'h8, 4'h9}) cost += 1 + delay;
      case (op)
         4'h0: m_a = m;
         4'h1, 4'h6, 4'h8, 4'h9: begin
            r = (op == 4'h1) ? m_a + m : (op == 4'h6) ? m_a - m : (op == 4'h8) ? (m_a & m) : (m_a | m);
            m_a = r;
            m_z = (r == 16'h0);
            m_n = r[15];
         end
         4'h4: begin
            m_n = (m_a < m);
            m_z = (m_a == m);
         end
         4'h3: mm[c[11:1]] = m_a;
         4'h2: m_pc = c;
         4'h5: if (m_z) m_pc = c;
         4'h7: if (m_n) m_pc = c;
         4'hA: m_a = {4'h0, c};
         4'hF: m_halt = 1'b1;
`ifdef MCU0_CALL_EN
         4'hB: begin
            m_lr = m_pc;
            m_pc = c;
         end
         4'hC: m_pc = m_lr;
`endif
         default: ;
      endcase
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 2048; i++) begin
         tmem[i] = 16'h0;
         mm[i]   = 16'h0;
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [15:0] w);
      tmem[a[11:1]] = w;
      mm[a[11:1]]   = w;
   endtask

   task automatic do_reset();
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("reset_bus", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'h0);
      chk("reset_core", {pc, acc, sw, halted}, 64'h0);
      @(posedge clock);
      #2 reset_n = 1'b1;
      m_pc = '0; m_lr = '0; m_a = '0; m_n = 1'b0; m_z = 1'b0; m_halt = 1'b0;
      @(negedge clock);
   endtask

   task automatic run_to_halt(input int budget, output int cyc);
      cyc = 0;
      while (halted !== 1'b1 && cyc < budget) begin
         @(posedge clock);
         @(negedge clock);
         cyc++;
      end
   endtask

   typedef struct {
      string        name;
      logic [167:0] img;      // six {addr[11:0], word[15:0]} pairs, first pair in the top bits
      logic [11:0]  exp_pc;
      logic [15:0]  exp_acc;
      logic [15:0]  exp_sw;
      int           exp_cyc;
      logic [11:0]  chk_a;
      logic [15:0]  chk_w;
   } vec_t;

   localparam logic [27:0] PAD = {12'h7F0, 16'h0000};
   vec_t vt[10];

   initial begin
      int          cyc, cost, diffs;
      logic [27:0] pr;
      logic [15:0] w;
      logic [3:0]  op;
      logic [11:0] c;
      logic [11:0] fpc;
      logic [15:0] facc;

      vt[0] = '{"T1_ld_add_st", {12'h000,16'h0010, 12'h002,16'h1012, 12'h004,16'h3014, 12'h006,16'hF000, 12'h010,16'h0005, 12'h012,16'h0003},
                12'h008, 16'h0008, 16'h0000, 11, 12'h014, 16'h0008};
      vt[1] = '{"T3_jeq", {12'h000,16'hA005, 12'h002,16'h4010, 12'h004,16'h5020, 12'h020,16'hF000, 12'h010,16'h0005, PAD},
                12'h022, 16'h0005, 16'h4000, 9, 12'h010, 16'h0005};
      vt[2] = '{"T3_jlt", {12'h000,16'hA003, 12'h002,16'h4010, 12'h004,16'h7030, 12'h030,16'hF000, 12'h010,16'h0005, PAD},
                12'h032, 16'h0003, 16'h8000, 9, 12'h010, 16'h0005};
      vt[3] = '{"T4_add_wrap", {12'h000,16'h0010, 12'h002,16'h1012, 12'h004,16'hF000, 12'h010,16'hFFFF, 12'h012,16'h0001, PAD},
                12'h006, 16'h0000, 16'h4000, 8, 12'h010, 16'hFFFF};
      vt[4] = '{"T4_ldi_sub", {12'h000,16'hA7FF, 12'h002,16'h6014, 12'h004,16'hF000, 12'h014,16'h0800, PAD, PAD},
                12'h006, 16'hFFFF, 16'h8000, 7, 12'h014, 16'h0800};
      vt[5] = '{"and_or", {12'h000,16'hA0F0, 12'h002,16'h8010, 12'h004,16'h9012, 12'h006,16'hF000, 12'h010,16'h003C, 12'h012,16'h8001},
                12'h008, 16'h8031, 16'h8000, 10, 12'h012, 16'h8001};
      vt[6] = '{"T5_nop_de", {12'h000,16'hD123, 12'h002,16'hE456, 12'h004,16'hA001, 12'h006,16'hF000, PAD, PAD},
                12'h008, 16'h0001, 16'h0000, 8, 12'h004, 16'hA001};
      vt[7] = '{"pc_wrap", {12'h000,16'h2FFE, 12'hFFE,16'hF000, PAD, PAD, PAD, PAD},
                12'h000, 16'h0000, 16'h0000, 4, 12'hFFE, 16'hF000};
`ifdef MCU0_CALL_EN
      vt[8] = '{"T6_call_ret", {12'h000,16'hA001, 12'h002,16'hA002, 12'h004,16'hB100, 12'h006,16'hF000, 12'h100,16'hA0FF, 12'h102,16'hC000},
                12'h008, 16'h00FF, 16'h0000, 12, 12'h100, 16'hA0FF};
`else
      vt[8] = '{"T6_call_nop", {12'h000,16'hA001, 12'h002,16'hA002, 12'h004,16'hB100, 12'h006,16'hF000, 12'h100,16'hA0FF, 12'h102,16'hC000},
                12'h008, 16'h0002, 16'h0000, 8, 12'h100, 16'hA0FF};
`endif
      vt[9] = '{"ld_keeps_flags", {12'h000,16'h4010, 12'h002,16'h0012, 12'h004,16'hF000, 12'h010,16'h0000, 12'h012,16'h8000, PAD},
                12'h006, 16'h8000, 16'h4000, 8, 12'h012, 16'h8000};

      // Directed programs, zero-wait memory
      for (int i = 0; i < 10; i++) begin
         clear_mem();
         for (int k = 0; k < 6; k++) begin
            pr = vt[i].img[(5-k)*28 +: 28];
            poke(pr[27:16], pr[15:0]);
         end
         delay = 0;
         noise = 1'b0;
         do_reset();
         run_to_halt(200, cyc);
         chk($sformatf("%s_cycles", vt[i].name), 64'(cyc), 64'(vt[i].exp_cyc));
         chk($sformatf("%s_state", vt[i].name), {pc, acc, sw, halted},
             {vt[i].exp_pc, vt[i].exp_acc, vt[i].exp_sw, 1'b1});
         chk($sformatf("%s_mem", vt[i].name), 64'(tmem[vt[i].chk_a[11:1]]), 64'(vt[i].chk_w));
         $display("vector %s: cycles=%0d pc=%h acc=%h sw=%h", vt[i].name, cyc, pc, acc, sw);
      end

      // T1 with three wait states on every access: 7 accesses each add 3 cycles
      clear_mem();
      poke(12'h000, 16'h0010); poke(12'h002, 16'h1012); poke(12'h004, 16'h3014);
      poke(12'h006, 16'hF000); poke(12'h010, 16'h0005); poke(12'h012, 16'h0003);
      delay = 3;
      do_reset();
      run_to_halt(200, cyc);
      chk("T2_cycles", 64'(cyc), 64'd32);
      chk("T2_state", {pc, acc, sw, halted}, {12'h008, 16'h0008, 16'h0000, 1'b1});
      chk("T2_mem", 64'(tmem[12'h014 >> 1]), 64'h0008);
      $display("vector T2: cycles=%0d acc=%h", cyc, acc);

      // Reset in the middle of a stalled fetch
      clear_mem();
      poke(12'h000, 16'hD000); poke(12'h002, 16'hE000); poke(12'h004, 16'hA005); poke(12'h006, 16'hF000);
      delay = 1000;
      do_reset();
      repeat (3) @(negedge clock);
      chk("T5_stalled_req", {bus.mem_req, bus.mem_addr}, {1'b1, 12'h000});
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1 chk("T5_async_drop", 64'(bus.mem_req), 64'h0);
      delay = 0;
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(negedge clock);
      run_to_halt(200, cyc);
      chk("T5_cycles", 64'(cyc), 64'd8);
      chk("T5_state", {pc, acc, halted}, {12'h008, 16'h0005, 1'b1});
      $display("vector T5: cycles=%0d pc=%h acc=%h", cyc, pc, acc);

      // HALT is terminal even with stray acks on the bus
      noise = 1'b1;
      fpc = pc;
      facc = acc;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         chk("halt_frozen", {bus.mem_req, halted, pc, acc}, {1'b0, 1'b1, fpc, facc});
      end
      $display("vector halt_frozen: pc=%h acc=%h", pc, acc);

      // Random programs against the instruction-level model
      for (int r = 0; r < 20; r++) begin
         clear_mem();
         for (int k = 0; k < 64; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hA;
            if (op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h6, 4'h8, 4'h9})
               c = 12'h080 | 12'($urandom_range(0, 63) << 1);
            else if (op inside {4'h2, 4'h5, 4'h7, 4'hB})
               c = 12'($urandom_range(0, 63) << 1);
            else
               c = 12'($urandom);
            w = {op, c};
            poke(12'(k * 2), w);
            poke(12'h080 + 12'(k * 2), 16'($urandom));
         end
         delay = $urandom_range(0, 2);
         noise = 1'b1;
         do_reset();
         for (int s = 0; s < 60; s++) begin
            model_step(cost);
            if (cost == 0) break;
            repeat (cost) begin
               @(posedge clock);
               @(negedge clock);
            end
            chk($sformatf("rnd%0d_step%0d", r, s), {pc, acc, sw, halted}, {m_pc, m_a, m_n, m_z, 14'h0, m_halt});
         end
         diffs = 0;
         for (int k = 12'h040; k < 12'h080; k++) if (tmem[k] !== mm[k]) diffs++;
         chk($sformatf("rnd%0d_mem", r), 64'(diffs), 64'h0);
         $display("vector rnd%0d: delay=%0d pc=%h acc=%h sw=%h halted=%b", r, delay, pc, acc, sw, halted);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
